// File: rtl/mask_axil_slave_if.sv
// AXI4-Lite slave bus plus mask result stream for the mask engine.
// Latency: none; this file only bundles the wires.
// Backpressure: AXI valid/ready on every channel; MASK_OUT valid/ready.
interface mask_axil_slave_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;
  logic [31:0]           MASK_OUT_DATA;
  logic [31:0]           MASK_OUT_ADDR;
  logic                  MASK_OUT_VALID;
  logic                  MASK_OUT_READY;
  logic                  MASK_DONE_PULSE;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, MASK_OUT_READY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output MASK_OUT_DATA, MASK_OUT_ADDR, MASK_OUT_VALID, MASK_DONE_PULSE
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, MASK_OUT_READY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  MASK_OUT_DATA, MASK_OUT_ADDR, MASK_OUT_VALID, MASK_DONE_PULSE
  );
endinterface

// File: rtl/mask_axil_slave.sv
// AXI4-Lite register bank driving a single-job engine that keeps the low N bits of DATA.
// Latency: B one edge after AW+W latched, R one edge after AR, MASK_OUT_VALID two edges after the VALID write handshake.
// Backpressure: AW/W/AR stall while their response is outstanding; MASK_OUT held until MASK_OUT_READY.
module mask_axil_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  mask_axil_slave_if.slave s_axi
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register indices are addr[7:2]
  localparam logic [5:0] IDX_N      = 6'd0;
  localparam logic [5:0] IDX_DATA   = 6'd1;
  localparam logic [5:0] IDX_OADDR  = 6'd2;
  localparam logic [5:0] IDX_VALID  = 6'd3;
  localparam logic [5:0] IDX_STATUS = 6'd4;
  localparam logic [5:0] IDX_RESULT = 6'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} job_state_t;

  job_state_t state_q;

  logic                  awready_q, wready_q, bvalid_q, aw_full_q, w_full_q;
  logic [1:0]            bresp_q;
  logic [5:0]            wr_idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  arready_q, ar_pend_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [5:0]            rd_idx_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [4:0]            n_q, snap_n_q;
  logic [DATA_WIDTH-1:0] data_q, oaddr_q, result_q;
  logic [DATA_WIDTH-1:0] snap_data_q, snap_addr_q, out_data_q, out_addr_q;
  logic                  valid_q, done_q, overrun_q, out_valid_q, pulse_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, commit, wr_ok, busy;
  logic                  aw_full_n, w_full_n, bvalid_n, rvalid_n;
  logic [DATA_WIDTH-1:0] rd_word, calc_mask;
  logic                  rd_ok;
  logic                  unused_bits;

  assign aw_hs  = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs   = s_axi.S_AXI_WVALID & wready_q;
  assign b_hs   = bvalid_q & s_axi.S_AXI_BREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_ok  = (wr_idx_q <= IDX_RESULT);
  assign busy   = (state_q != ST_IDLE);

  // A latched beat is held until its B response is accepted
  assign aw_full_n = b_hs ? 1'b0 : (aw_full_q | aw_hs);
  assign w_full_n  = b_hs ? 1'b0 : (w_full_q | w_hs);
  assign bvalid_n  = commit | (bvalid_q & ~s_axi.S_AXI_BREADY);
  assign rvalid_n  = ar_pend_q | (rvalid_q & ~s_axi.S_AXI_RREADY);

  // WSTRB and address bits outside [7:2] do not take part in decode
  assign unused_bits = ^{s_axi.S_AXI_WSTRB,
                         s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:8], s_axi.S_AXI_AWADDR[1:0],
                         s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:8], s_axi.S_AXI_ARADDR[1:0]};

  // Read mux over the current register values (pre-update on the response edge)
  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b1;
    case (rd_idx_q)
      IDX_N:      rd_word = {27'd0, n_q};
      IDX_DATA:   rd_word = data_q;
      IDX_OADDR:  rd_word = oaddr_q;
      IDX_VALID:  rd_word = {31'd0, valid_q};
      IDX_STATUS: rd_word = {29'd0, overrun_q, done_q, busy};
      IDX_RESULT: rd_word = result_q;
      default:    rd_ok   = 1'b0;
    endcase
  end

  // Low-N-bit mask; N==0 passes DATA through untouched
  always_comb begin
    calc_mask = '1;
    if (snap_n_q != 5'd0) calc_mask = (DATA_WIDTH'(1) << snap_n_q) - DATA_WIDTH'(1);
  end

  // Write channel: AW/W latches, commit strobe and B response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      awready_q <= ~aw_full_n & ~bvalid_n;
      wready_q  <= ~w_full_n & ~bvalid_n;
      aw_full_q <= aw_full_n;
      w_full_q  <= w_full_n;
      bvalid_q  <= bvalid_n;
      if (aw_hs)  wr_idx_q  <= s_axi.S_AXI_AWADDR[7:2];
      if (w_hs)   wr_data_q <= s_axi.S_AXI_WDATA;
      if (commit) bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel: latch AR, answer on the next edge, hold until RREADY
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      ar_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rd_idx_q  <= '0;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~ar_hs & ~rvalid_n;
      ar_pend_q <= ar_hs;
      rvalid_q  <= rvalid_n;
      if (ar_hs) rd_idx_q <= s_axi.S_AXI_ARADDR[7:2];
      if (ar_pend_q) begin
        rdata_q <= rd_word;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Register file commits and job FSM; status sets are ordered after W1C so sets win
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      data_q      <= '0;
      oaddr_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      result_q    <= '0;
      snap_n_q    <= '0;
      snap_data_q <= '0;
      snap_addr_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (commit) begin
        case (wr_idx_q)
          IDX_N:     n_q     <= wr_data_q[4:0];
          IDX_DATA:  data_q  <= wr_data_q;
          IDX_OADDR: oaddr_q <= wr_data_q;
          IDX_VALID: begin
            if (wr_data_q[0]) begin
              if (state_q == ST_IDLE) begin
                valid_q     <= 1'b1;
                snap_n_q    <= n_q;
                snap_data_q <= data_q;
                snap_addr_q <= oaddr_q;
                state_q     <= ST_CALC;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
          IDX_STATUS: begin
            if (wr_data_q[1]) done_q    <= 1'b0;
            if (wr_data_q[2]) overrun_q <= 1'b0;
          end
          default: ;
        endcase
      end
      case (state_q)
        ST_CALC: begin
          result_q    <= snap_data_q & calc_mask;
          out_data_q  <= snap_data_q & calc_mask;
          out_addr_q  <= snap_addr_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_valid_q && s_axi.MASK_OUT_READY) begin
            out_valid_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b1;
            pulse_q     <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY   = awready_q;
  assign s_axi.S_AXI_WREADY    = wready_q;
  assign s_axi.S_AXI_BVALID    = bvalid_q;
  assign s_axi.S_AXI_BRESP     = bresp_q;
  assign s_axi.S_AXI_ARREADY   = arready_q;
  assign s_axi.S_AXI_RVALID    = rvalid_q;
  assign s_axi.S_AXI_RDATA     = rdata_q;
  assign s_axi.S_AXI_RRESP     = rresp_q;
  assign s_axi.MASK_OUT_DATA   = out_data_q;
  assign s_axi.MASK_OUT_ADDR   = out_addr_q;
  assign s_axi.MASK_OUT_VALID  = out_valid_q;
  assign s_axi.MASK_DONE_PULSE = pulse_q;

endmodule
